// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation at a time, waits EXEC_CYCLES, captures the 64-bit result
// and returns it as one or two 32-bit beats under valid/ready.
module alu_op_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_y,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_control,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, SEND_LO, SEND_HI} state_t;

  localparam logic [3:0] C_CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_z;
  logic        r_two_beat;
  logic        r_err;

  logic        w_legal;
  logic        w_two_beat;

  always_comb begin
    w_legal = 1'b0;
    case (req_op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
      5'b10000, 5'b10001, 5'b10010, 5'b11111: w_legal = 1'b1;
      default:                                  w_legal = 1'b0;
    endcase
    w_two_beat = (req_op == 5'b01111) || (req_op == 5'b10000);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_z         <= 64'd0;
      r_two_beat  <= 1'b0;
      r_err       <= 1'b0;
      alu_y       <= 32'd0;
      alu_b       <= 32'd0;
      alu_control <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            alu_y       <= req_a;
            alu_b       <= req_b;
            alu_control <= req_op;
            r_two_beat  <= w_two_beat && w_legal;
            r_err       <= !w_legal;
            r_cnt       <= C_CNT_INIT;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          // Result is sampled only on the last EXEC cycle; ALU glitches elsewhere are ignored.
          if (r_cnt == 4'd0) begin
            r_z     <= alu_result;
            r_state <= SEND_LO;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        SEND_LO: begin
          if (rsp_ready) r_state <= r_two_beat ? SEND_HI : IDLE;
        end
        SEND_HI: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == SEND_LO) || (r_state == SEND_HI);
    rsp_data  = 32'd0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    if (r_state == SEND_LO) begin
      rsp_data = r_z[31:0];
      rsp_last = !r_two_beat;
      rsp_err  = r_err;
    end else if (r_state == SEND_HI) begin
      rsp_data = r_z[63:32];
      rsp_last = 1'b1;
      rsp_err  = r_err;
    end
  end

endmodule
